// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion scheduler: one shared adder/compare datapath walks all
// sprites once per frame, then publishes every position in a single COMMIT cycle.
module sprite_motion_ctrl #(
  parameter int CORDW     = 16,
  parameter int NSPR      = 4,
  parameter int VELW      = 8,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPR_DRAWW = 128,
  parameter int SPR_DRAWH = 80,
  parameter int IDXW      = $clog2(NSPR)
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    frame,
  input  logic                    cfg_we,
  input  logic [IDXW-1:0]         cfg_idx,
  input  logic [CORDW-1:0]        cfg_x,
  input  logic [CORDW-1:0]        cfg_y,
  input  logic [VELW-1:0]         cfg_vx,
  input  logic [VELW-1:0]         cfg_vy,
  input  logic [1:0]              cfg_mode,
  output logic                    cfg_ready,
  output logic [NSPR*CORDW-1:0]   sprx_flat,
  output logic [NSPR*CORDW-1:0]   spry_flat,
  output logic                    busy,
  output logic                    done,
  output logic [NSPR-1:0]         hit,
  output logic                    overrun
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} state_t;

  typedef struct packed {
    logic signed [CORDW-1:0] pos;
    logic signed [VELW-1:0]  vel;
    logic                    hit;
  } axis_t;

  // Bounds live in CORDW+1 bits so x+v can never overflow before the compare.
  localparam logic signed [CORDW:0] XMAX = (CORDW+1)'(H_RES);
  localparam logic signed [CORDW:0] YMAX = (CORDW+1)'(V_RES);
  localparam logic signed [CORDW:0] XNEG = -((CORDW+1)'(SPR_DRAWW));
  localparam logic signed [CORDW:0] YNEG = -((CORDW+1)'(SPR_DRAWH));
  localparam logic signed [CORDW:0] XLIM = (CORDW+1)'(H_RES - SPR_DRAWW);
  localparam logic signed [CORDW:0] YLIM = (CORDW+1)'(V_RES - SPR_DRAWH);
  localparam logic [CORDW-1:0]      XRST = CORDW'(H_RES);
  localparam logic signed [VELW-1:0] VMIN = {1'b1, {(VELW-1){1'b0}}};
  localparam logic signed [VELW-1:0] VMAX = {1'b0, {(VELW-1){1'b1}}};
  localparam logic [IDXW-1:0]       LAST = IDXW'(NSPR - 1);
  localparam logic [IDXW:0]         NSPR_W = (IDXW+1)'(NSPR);

  function automatic axis_t step_axis(
    input logic signed [CORDW-1:0] p,
    input logic signed [VELW-1:0]  v,
    input logic [1:0]              mode,
    input logic signed [CORDW:0]   hi,
    input logic signed [CORDW:0]   neg,
    input logic signed [CORDW:0]   clamp
  );
    axis_t r;
    logic signed [CORDW:0]  n;
    logic signed [VELW-1:0] vneg;
    logic                   vpos;
    r.pos = p;
    r.vel = v;
    r.hit = 1'b0;
    n     = (CORDW+1)'(p) + (CORDW+1)'(v);
    vneg  = (v == VMIN) ? VMAX : -v;
    vpos  = !v[VELW-1] && (v != '0);
    case (mode)
      2'd1: begin
        if (v[VELW-1] && n <= neg)  r.pos = hi[CORDW-1:0];
        else if (vpos && n >= hi)   r.pos = neg[CORDW-1:0];
        else                        r.pos = n[CORDW-1:0];
      end
      2'd2: begin
        // A parked sprite outside the box must not be yanked back in.
        if (v != '0) begin
          if (n[CORDW]) begin
            r.pos = '0;
            r.vel = vneg;
            r.hit = 1'b1;
          end else if (n > clamp) begin
            r.pos = clamp[CORDW-1:0];
            r.vel = vneg;
            r.hit = 1'b1;
          end else begin
            r.pos = n[CORDW-1:0];
          end
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q;
  logic signed [CORDW-1:0]     x_r  [NSPR];
  logic signed [CORDW-1:0]     y_r  [NSPR];
  logic signed [VELW-1:0]      vx_r [NSPR];
  logic signed [VELW-1:0]      vy_r [NSPR];
  logic [1:0]                  mode_r [NSPR];
  logic [NSPR-1:0]             hit_work;
  logic [NSPR-1:0][CORDW-1:0]  sprx_q, spry_q;
  logic [NSPR-1:0]             hit_q;
  logic                        done_q, overrun_q;
  axis_t                       ax, ay;

  always_comb begin
    ax = step_axis(x_r[idx_q], vx_r[idx_q], mode_r[idx_q], XMAX, XNEG, XLIM);
    ay = step_axis(y_r[idx_q], vy_r[idx_q], mode_r[idx_q], YMAX, YNEG, YLIM);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame) state_d = S_UPDATE;
      S_UPDATE: if (idx_q == LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      hit_work  <= '0;
      hit_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NSPR; i++) begin
        x_r[i]    <= XRST;
        y_r[i]    <= '0;
        vx_r[i]   <= '0;
        vy_r[i]   <= '0;
        mode_r[i] <= 2'd0;
        sprx_q[i] <= XRST;
        spry_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (frame && state_q != S_IDLE) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cfg_we && ({1'b0, cfg_idx} < NSPR_W)) begin
            x_r[cfg_idx]    <= cfg_x;
            y_r[cfg_idx]    <= cfg_y;
            vx_r[cfg_idx]   <= cfg_vx;
            vy_r[cfg_idx]   <= cfg_vy;
            mode_r[cfg_idx] <= cfg_mode;
          end
          if (frame) begin
            idx_q    <= '0;
            hit_work <= '0;
          end
        end
        S_UPDATE: begin
          x_r[idx_q]      <= ax.pos;
          y_r[idx_q]      <= ay.pos;
          vx_r[idx_q]     <= ax.vel;
          vy_r[idx_q]     <= ay.vel;
          hit_work[idx_q] <= ax.hit | ay.hit;
          idx_q           <= idx_q + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < NSPR; i++) begin
            sprx_q[i] <= x_r[i];
            spry_q[i] <= y_r[i];
          end
          hit_q  <= hit_work;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign cfg_ready = !busy;
  assign done      = done_q;
  assign hit       = hit_q;
  assign overrun   = overrun_q;
  assign sprx_flat = sprx_q;
  assign spry_flat = spry_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed + randomized bench for sprite_motion_ctrl against an integer motion model.
module tb_sprite_motion_ctrl;
  localparam int CORDW = 16, NSPR = 4, VELW = 8, IDXW = 2;
  localparam int H = 640, V = 480, DW = 128, DH = 80;

  logic clk_pix = 1'b0;
  logic rst_pix_n, frame, cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [CORDW-1:0] cfg_x, cfg_y;
  logic [VELW-1:0] cfg_vx, cfg_vy;
  logic [1:0] cfg_mode;
  logic cfg_ready, busy, done, overrun;
  logic [NSPR*CORDW-1:0] sprx_flat, spry_flat;
  logic [NSPR-1:0] hit;

  sprite_motion_ctrl #(.CORDW(CORDW), .NSPR(NSPR), .VELW(VELW), .H_RES(H), .V_RES(V),
                       .SPR_DRAWW(DW), .SPR_DRAWH(DH), .IDXW(IDXW)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .cfg_mode(cfg_mode), .cfg_ready(cfg_ready), .sprx_flat(sprx_flat),
    .spry_flat(spry_flat), .busy(busy), .done(done), .hit(hit), .overrun(overrun));

  always #5 clk_pix = ~clk_pix;

  int n_chk = 0, n_fail = 0;
  int mx[NSPR], my[NSPR], mvx[NSPR], mvy[NSPR], mmode[NSPR];
  int px[NSPR], py[NSPR];
  int mhit;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pub_x(input int i);
    logic signed [CORDW-1:0] v;
    v = sprx_flat[i*CORDW +: CORDW];
    return int'(v);
  endfunction

  function automatic int pub_y(input int i);
    logic signed [CORDW-1:0] v;
    v = spry_flat[i*CORDW +: CORDW];
    return int'(v);
  endfunction

  function automatic int vneg(input int v);
    return (v == -(1 << (VELW-1))) ? (1 << (VELW-1)) - 1 : -v;
  endfunction

  // One axis of motion, straight from the wrap/bounce rules.
  function automatic void axis(inout int p, inout int v, input int mode, input int res,
                               input int draw, inout bit h);
    int n;
    n = p + v;
    if (mode == 1) begin
      if (v < 0 && n <= -draw)      p = res;
      else if (v > 0 && n >= res)   p = -draw;
      else                          p = n;
    end else if (mode == 2 && v != 0) begin
      if (n < 0) begin
        p = 0; v = vneg(v); h = 1'b1;
      end else if (n > res - draw) begin
        p = res - draw; v = vneg(v); h = 1'b1;
      end else p = n;
    end
  endfunction

  function automatic void model_frame();
    mhit = 0;
    for (int i = 0; i < NSPR; i++) begin
      bit h = 1'b0;
      axis(mx[i], mvx[i], mmode[i], H, DW, h);
      axis(my[i], mvy[i], mmode[i], V, DH, h);
      if (h) mhit |= (1 << i);
      px[i] = mx[i];
      py[i] = my[i];
    end
  endfunction

  function automatic void model_reset();
    mhit = 0;
    for (int i = 0; i < NSPR; i++) begin
      mx[i] = H; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mmode[i] = 0;
      px[i] = H; py[i] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic check_pub(input string tag);
    for (int i = 0; i < NSPR; i++) begin
      chk($sformatf("%s_x%0d", tag, i), pub_x(i), px[i]);
      chk($sformatf("%s_y%0d", tag, i), pub_y(i), py[i]);
    end
    chk({tag, "_hit"}, int'(hit), mhit);
  endtask

  task automatic set_cfg(input int i, input int x, input int y, input int vx, input int vy,
                         input int mode);
    cfg_idx = IDXW'(i); cfg_x = CORDW'(x); cfg_y = CORDW'(y);
    cfg_vx = VELW'(vx); cfg_vy = VELW'(vy); cfg_mode = 2'(mode);
    cfg_we = 1'b1;
    mx[i] = x; my[i] = y; mvx[i] = vx; mvy[i] = vy; mmode[i] = (mode == 3) ? 0 : mode;
  endtask

  task automatic cfg_write(input int i, input int x, input int y, input int vx, input int vy,
                           input int mode);
    set_cfg(i, x, y, vx, vy, mode);
    tick();
    cfg_we = 1'b0;
  endtask

  // Frame asserted in cycle 0; busy through cycle NSPR+1; publish at NSPR+2.
  task automatic run_frame(input string tag);
    chk({tag, "_ready"}, int'(cfg_ready), 1);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    cfg_we = 1'b0;
    for (int k = 1; k <= NSPR + 1; k++) begin
      chk($sformatf("%s_busy_c%0d", tag, k), int'(busy), 1);
      chk($sformatf("%s_done_c%0d", tag, k), int'(done), 0);
      chk($sformatf("%s_hold_c%0d", tag, k), pub_x(0), px[0]);
      tick();
    end
    model_frame();
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_off"}, int'(busy), 0);
    check_pub(tag);
    tick();
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    rst_pix_n = 1'b0; frame = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_x = '0; cfg_y = '0; cfg_vx = '0; cfg_vy = '0; cfg_mode = '0;
    model_reset();
    tick(); tick();
    rst_pix_n = 1'b1;
    tick();
    check_pub("reset");
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_ready", int'(cfg_ready), 1);

    // Timing + basic wrap move
    cfg_write(0, 100, 0, -2, 0, 1);
    run_frame("timing");
    chk("timing_98", pub_x(0), 98);

    // Wrap boundaries
    cfg_write(0, -126, 0, -2, 0, 1);
    run_frame("wrap_left");
    chk("wrap_left_640", pub_x(0), 640);
    cfg_write(0, 638, 0, 2, 0, 1);
    run_frame("wrap_right");
    chk("wrap_right_m128", pub_x(0), -128);

    // Bounce on both axes, then hit clears next frame
    cfg_write(1, 510, 2, 4, -5, 2);
    run_frame("bounce1");
    chk("bounce1_x512", pub_x(1), 512);
    chk("bounce1_y0", pub_y(1), 0);
    chk("bounce1_hit1", int'(hit[1]), 1);
    run_frame("bounce2");
    chk("bounce2_x508", pub_x(1), 508);
    chk("bounce2_y5", pub_y(1), 5);
    chk("bounce2_hit1", int'(hit[1]), 0);

    // Most-negative velocity negates to positive maximum
    cfg_write(2, 5, 300, -128, 0, 2);
    run_frame("sat1");
    chk("sat1_x0", pub_x(2), 0);
    run_frame("sat2");
    chk("sat2_x127", pub_x(2), 127);

    // Write and frame in the same idle cycle
    set_cfg(3, 200, 100, 3, -3, 1);
    run_frame("samecyc");
    chk("samecyc_x203", pub_x(3), 203);

    // Contention: write dropped while busy, second frame ignored
    chk("pre_overrun", int'(overrun), 0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    cfg_idx = 2'd0; cfg_x = 16'd333; cfg_y = 16'd222; cfg_vx = 8'd9; cfg_vy = 8'd9;
    cfg_mode = 2'd1; cfg_we = 1'b1;
    chk("cont_ready", int'(cfg_ready), 0);
    tick();
    cfg_we = 1'b0;
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("cont_overrun", int'(overrun), 1);
    tick(); tick();
    model_frame();
    chk("cont_done", int'(done), 1);
    check_pub("cont");
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) dcount++;
    end
    chk("cont_single_done", dcount, 0);
    chk("cont_idle", int'(busy), 0);
    run_frame("cont_after");

    // Randomized configurations
    for (int f = 0; f < 10; f++) begin
      int nw;
      nw = int'($urandom_range(3));
      for (int w = 0; w < nw; w++)
        cfg_write(int'($urandom_range(NSPR-1)), int'($urandom_range(1000)) - 200,
                  int'($urandom_range(700)) - 150, int'($urandom_range(255)) - 128,
                  int'($urandom_range(255)) - 128, int'($urandom_range(3)));
      run_frame($sformatf("rnd%0d", f));
    end
    chk("overrun_sticky", int'(overrun), 1);

    // Async reset during the third update cycle
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick(); tick();
    #2 rst_pix_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_ready", int'(cfg_ready), 1);
    check_pub("arst");
    tick(); tick();
    chk("arst_hold_done", int'(done), 0);
    rst_pix_n = 1'b1;
    tick();
    chk("arst_rel_done", int'(done), 0);
    run_frame("post_rst");
    for (int i = 0; i < NSPR; i++) begin
      chk($sformatf("post_rst_x%0d_640", i), pub_x(i), 640);
      chk($sformatf("post_rst_y%0d_0", i), pub_y(i), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame motion scheduler for up to NSPR hardware sprites. One shared adder/compare datapath is time-multiplexed across the sprites, one sprite per cycle, on each frame pulse. It applies wrap or bounce rules and then publishes all sprite positions atomically to the sprite engines. It sits between the display timing generator (frame) and the sprite instances (sprx/spry), and replaces ad-hoc per-sprite position logic in top-level designs.

Parameters:
CORDW, 16, signed coordinate width (bits)
NSPR, 4, number of sprites (2..16)
VELW, 8, signed velocity width (bits)
H_RES, 640, horizontal active pixels
V_RES, 480, vertical active lines
SPR_DRAWW, 128, sprite draw width (pixels, after scaling)
SPR_DRAWH, 80, sprite draw height (lines, after scaling)
IDXW, $clog2(NSPR), sprite index width

Ports:
clk_pix  in  1  pixel clock
rst_pix_n  in  1  asynchronous active-low reset
frame  in  1  start-of-frame pulse from display timing
cfg_we  in  1  configuration write strobe
cfg_idx  in  IDXW  sprite index to write
cfg_x  in  CORDW  signed x position
cfg_y  in  CORDW  signed y position
cfg_vx  in  VELW  signed x velocity (pixels/frame)
cfg_vy  in  VELW  signed y velocity
cfg_mode  in  2  0=stop, 1=wrap, 2=bounce, 3=reserved (treated as stop)
cfg_ready  out  1  write accepted when high (= !busy)
sprx_flat  out  NSPR*CORDW  published x, sprite i at bits [i*CORDW +: CORDW]
spry_flat  out  NSPR*CORDW  published y, same packing
busy  out  1  update sequence in progress
done  out  1  one-cycle pulse: new positions published
hit  out  NSPR  per-sprite bounce event in last completed frame
overrun  out  1  sticky: frame arrived while busy

Behaviour:
- Reset (async, rst_pix_n=0) forces:
  - working x=H_RES, y=0, vx=vy=0, mode=stop
  - sprx_flat all H_RES, spry_flat all 0
  - busy=0, done=0, hit=0, overrun=0
  - FSM=IDLE
  - Reset asserted mid-update aborts the update immediately; no partial publish.
- Config writes:
  - Accepted only when cfg_we && cfg_ready. cfg_we while busy is dropped silently.
  - Writes go to working registers only. They become visible on sprx/spry_flat at the next COMMIT.
- FSM states and transitions:
  - IDLE: frame -> UPDATE with idx=0.
    - frame and cfg_we in the same IDLE cycle: the write is applied, and the update uses the new values.
  - UPDATE: processes sprite idx in one cycle, idx++. After idx=NSPR-1 -> COMMIT.
  - COMMIT: loads all working x/y into the published registers and loads hit from the frame's bounce flags; done=1 and busy=0 from the next cycle -> IDLE.
- Latency:
  - frame in cycle t gives busy=1 in cycles t+1..t+1+NSPR.
  - Outputs change, done pulses and busy falls at t+2+NSPR (NSPR=4: t+6).
- Overrun: frame while busy is ignored (no restart) and sets overrun=1 until reset.
- Arithmetic:
  - Sign-extend the velocity and compute in CORDW+1 bits; nx = x+vx, ny = y+vy.
- Stop: x, y, v unchanged; no hit.
- Wrap, x axis:
  - if vx<0 and nx <= -SPR_DRAWW, x=H_RES
  - else if vx>0 and nx >= H_RES, x=-SPR_DRAWW
  - else x=nx
- Wrap, y axis: same rule with V_RES and SPR_DRAWH.
- Bounce, x axis:
  - if nx<0, x=0 and vx=-vx
  - else if nx > H_RES-SPR_DRAWW, x=H_RES-SPR_DRAWW and vx=-vx
  - else x=nx
  - either clamp sets hit[idx]
- Bounce, y axis: same rule with 0..V_RES-SPR_DRAWH.
- Velocity 0 in any mode leaves that axis unchanged.
- Negating the most negative vx/vy saturates to its positive maximum.
- hit bits not set in the current frame read 0 after COMMIT.

Test Plan:
- Reset, then check outputs -> every sprx=640, spry=0; busy=0, hit=0, overrun=0, cfg_ready=1.
- Timing: sprite0 x=100, vx=-2, mode=wrap; frame at cycle 0 -> busy cycles 1..5; done=1 and sprx[0]=98 at cycle 6; no output change before cycle 6.
- Wrap: sprite0 x=-126, vx=-2, wrap; frame -> sprx[0]=640. Then x=638, vx=+2 -> -128.
- Bounce: sprite1 x=510, vx=+4, bounce -> x=512, hit[1]=1. Next frame -> x=508, hit[1]=0. Also y=2, vy=-5 -> y=0, vy=+5, hit set.
- Contention: frame at cycle 0, cfg_we at cycle 2, frame at cycle 3 -> cfg_ready=0, write dropped (working regs unchanged), overrun=1, single done at cycle 6.
- Async reset: assert rst_pix_n=0 in UPDATE cycle 3 -> immediately busy=0 and sprx=640, with no done pulse. After release, frame -> all stop-mode sprites unchanged.
